// File: rtl/switch_alu_top.sv
// Switch-loaded operand/opcode register bank feeding a combinational 8-bit ALU that drives the LEDs.
// Result follows the loading edge with zero latency, or one clock when ALU_OUT_REG_EN is defined; no backpressure.

module switch_alu_regs #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6,
   parameter int NB_BTN  = 3
) (
   input  logic               i_clock,
   input  logic               i_rst_n,
   input  logic [NB_BTN-1:0]  i_btn,
   input  logic [NB_DATA-1:0] i_sw,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op
);

   logic [NB_DATA-1:0] r_data_a;
   logic [NB_DATA-1:0] r_data_b;
   logic [NB_OP-1:0]   r_op;

   // Buttons are level enables: a held button reloads on every edge.
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data_a <= '0;
         r_data_b <= '0;
         r_op     <= '0;
      end else begin
         if (i_btn[0]) r_data_a <= i_sw;
         if (i_btn[1]) r_data_b <= i_sw;
         if (i_btn[2]) r_op     <= i_sw[NB_OP-1:0];
      end
   end

   assign o_data_a = r_data_a;
   assign o_data_b = r_data_b;
   assign o_op     = r_op;

endmodule

module switch_alu_core #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic [NB_DATA-1:0] i_data_a,
   input  logic [NB_DATA-1:0] i_data_b,
   input  logic [NB_OP-1:0]   i_op,
   output logic [NB_DATA-1:0] o_result
);

   localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(32);
   localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(34);
   localparam logic [NB_OP-1:0] OP_AND = NB_OP'(36);
   localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(37);
   localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(38);
   localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(39);
   localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(3);
   localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(2);

   // Shifts use the full unsigned B; oversized amounts saturate to zero/sign fill.
   always_comb begin
      o_result = '0;
      case (i_op)
         OP_ADD:  o_result = i_data_a + i_data_b;
         OP_SUB:  o_result = i_data_a - i_data_b;
         OP_AND:  o_result = i_data_a & i_data_b;
         OP_OR:   o_result = i_data_a | i_data_b;
         OP_XOR:  o_result = i_data_a ^ i_data_b;
         OP_NOR:  o_result = ~(i_data_a | i_data_b);
         OP_SRA:  o_result = $signed(i_data_a) >>> i_data_b;
         OP_SRL:  o_result = i_data_a >> i_data_b;
         default: o_result = '0;
      endcase
   end

endmodule

module switch_alu_top #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6,
   parameter int NB_BTN  = 3
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_BTN-1:0]  i_btn,
   input  logic [NB_DATA-1:0] i_sw,
   output logic [NB_DATA-1:0] o_led
);

   logic [1:0]         r_rst_sync;
   logic               w_rst_n;
   logic [NB_DATA-1:0] w_data_a;
   logic [NB_DATA-1:0] w_data_b;
   logic [NB_OP-1:0]   w_op;
   logic [NB_DATA-1:0] w_result;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   switch_alu_regs #(
      .NB_DATA (NB_DATA),
      .NB_OP   (NB_OP),
      .NB_BTN  (NB_BTN)
   ) u_regs (
      .i_clock  (i_clock),
      .i_rst_n  (w_rst_n),
      .i_btn    (i_btn),
      .i_sw     (i_sw),
      .o_data_a (w_data_a),
      .o_data_b (w_data_b),
      .o_op     (w_op)
   );

   switch_alu_core #(
      .NB_DATA (NB_DATA),
      .NB_OP   (NB_OP)
   ) u_core (
      .i_data_a (w_data_a),
      .i_data_b (w_data_b),
      .i_op     (w_op),
      .o_result (w_result)
   );

`ifdef ALU_OUT_REG_EN
   logic [NB_DATA-1:0] r_led;

   always_ff @(posedge i_clock or negedge w_rst_n) begin
      if (!w_rst_n) r_led <= '0;
      else          r_led <= w_result;
   end

   assign o_led = r_led;
`else
   assign o_led = w_result;
`endif

endmodule

// File: tb/tb_switch_alu_top.sv
// Randomised self-checking bench for switch_alu_top against an arithmetic reference model.
// Define ALU_OUT_REG_EN to check the registered-output build with one extra cycle of latency.

module tb_switch_alu_top;

`ifdef ALU_OUT_REG_EN
   localparam bit LAT = 1'b1;
`else
   localparam bit LAT = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [2:0] btn;
   logic [7:0] sw;
   logic [7:0] led;

   int n_chk;
   int n_err;
   int ma, mb, mop, m_prev;

   switch_alu_top dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .i_btn   (btn),
      .i_sw    (sw),
      .o_led   (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   function automatic int ref_alu(input int a, input int b, input int op);
      int sa;
      case (op)
         32: return (a + b) % 256;
         34: return (a - b + 256) % 256;
         36: return a & b;
         37: return a | b;
         38: return a ^ b;
         39: return 255 - (a | b);
         3: begin
            sa = (a >= 128) ? a - 256 : a;
            if (b >= 8) return (sa < 0) ? 255 : 0;
            return (sa >>> b) & 255;
         end
         2: return (b >= 8) ? 0 : (a >> b);
         default: return 0;
      endcase
   endfunction

   // One loading edge between two falling edges; model follows the same register picks.
   task automatic press(input logic [2:0] b, input logic [7:0] v);
      @(negedge clk);
      btn = b;
      sw  = v;
      m_prev = ref_alu(ma, mb, mop);
      if (b[0]) ma = v;
      if (b[1]) mb = v;
      if (b[2]) mop = v & 63;
      @(negedge clk);
      btn = 3'b000;
   endtask

   task automatic check_led(input string tag);
      int exp;
      exp = ref_alu(ma, mb, mop);
      if (LAT) begin
         chk_val({tag, "_lat"}, led, 8'(m_prev));
         @(negedge clk);
      end
      chk_val(tag, led, 8'(exp));
   endtask

   task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input string tag);
      press(3'b001, a);
      press(3'b010, b);
      press(3'b100, op);
      check_led(tag);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int ops[9];
      int a, b;
      n_chk = 0;
      n_err = 0;
      ma = 0; mb = 0; mop = 0; m_prev = 0;
      rst_n = 1'b0;
      btn   = 3'b000;
      sw    = 8'h00;
      #1;
      chk_val("reset", led, 8'h00);
      repeat (2) @(negedge clk);
      release_reset();
      chk_val("idle", led, 8'h00);

      load3(8'h0F, 8'h01, 8'd32, "add");
      press(3'b100, 8'd34);
      check_led("sub");
      load3(8'h00, 8'h01, 8'd34, "sub_wrap");
      load3(8'hFF, 8'h01, 8'd32, "add_wrap");
      load3(8'h80, 8'h01, 8'd3,  "sra1");
      press(3'b100, 8'd2);
      check_led("srl1");
      press(3'b010, 8'h09);
      check_led("srl9");
      press(3'b100, 8'd3);
      check_led("sra9");
      press(3'b010, 8'h00);
      check_led("sra0");
      load3(8'h0F, 8'hF0, 8'd36, "and");
      press(3'b100, 8'd37); check_led("or");
      press(3'b100, 8'd38); check_led("xor");
      press(3'b100, 8'd39); check_led("nor");
      press(3'b100, 8'd1);  check_led("bad_op");

      load3(8'h35, 8'h12, 8'd32, "pre_rst");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_val("async_rst", led, 8'h00);
      ma = 0; mb = 0; mop = 0;
      #1;
      release_reset();
      chk_val("post_rst", led, 8'h00);
      press(3'b111, 8'h22);
      check_led("all_btn");
      load3(8'h22, 8'h01, 8'd32, "all_btn_add");

      ops = '{32, 34, 36, 37, 38, 39, 3, 2, 0};
      foreach (ops[k]) begin
         for (int i = 0; i < 11; i++) begin
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 11) : $urandom_range(0, 255);
            if (k == 8) load3(8'(a), 8'(b), 8'($urandom_range(0, 255) & 8'h1C), "rnd_bad");
            else        load3(8'(a), 8'(b), 8'(ops[k]), $sformatf("rnd_op%0d", ops[k]));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
